// File: rtl/lcd_bus_controller.sv
// HD44780-style LCD bus sequencer: one byte transfer per request with setup,
// enable-pulse and hold timing, plus optional busy-flag polling after writes.
module lcd_bus_controller #(
  parameter int T_SETUP  = 2,
  parameter int T_ENABLE = 12,
  parameter int T_HOLD   = 2,
  parameter bit POLL_EN  = 1'b1,
  parameter int POLL_MAX = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic       reqRS,
  input  logic       reqRW,
  input  logic [7:0] reqData,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       timeout,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic       lcdE,
  output logic [7:0] lcdDataOut,
  output logic       lcdDataOe,
  input  logic [7:0] lcdDataIn
);

  localparam int T_MAX = (T_SETUP > T_ENABLE)
                       ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                       : ((T_ENABLE > T_HOLD) ? T_ENABLE : T_HOLD);
  localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] ENABLE_LAST = CW'(T_ENABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(T_HOLD - 1);
  localparam logic [PW-1:0] POLL_LIMIT  = PW'(POLL_MAX);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ENABLE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pollCnt;
  logic          pollFlag;
  logic          latRS;
  logic          latRW;
  logic [7:0]    latData;
  logic [7:0]    rdData;
  logic          lastCycle;
  logic          inXfer;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    lastCycle = 1'b0;
    case (state)
      SETUP:   lastCycle = (cnt == SETUP_LAST);
      ENABLE:  lastCycle = (cnt == ENABLE_LAST);
      HOLD:    lastCycle = (cnt == HOLD_LAST);
      default: lastCycle = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pollCnt  <= '0;
      pollFlag <= 1'b0;
      latRS    <= 1'b0;
      latRW    <= 1'b0;
      latData  <= '0;
      rdData   <= '0;
      rspValid <= 1'b0;
      rspData  <= '0;
      timeout  <= 1'b0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            latRS    <= reqRS;
            latRW    <= reqRW;
            latData  <= reqData;
            timeout  <= 1'b0;
            pollCnt  <= '0;
            pollFlag <= 1'b0;
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (lastCycle) begin
            cnt   <= '0;
            state <= ENABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ENABLE: begin
          if (lastCycle) begin
            rdData <= lcdDataIn;
            cnt    <= '0;
            state  <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (!lastCycle) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!pollFlag && (latRW || !POLL_EN)) begin
              state    <= IDLE;
              rspValid <= 1'b1;
              rspData  <= latRW ? rdData : 8'h00;
            end else if (pollFlag && (!rdData[7] || pollCnt == POLL_LIMIT)) begin
              state    <= IDLE;
              rspValid <= 1'b1;
              rspData  <= rdData;
              timeout  <= rdData[7];
            end else begin
              // Busy-flag read goes straight back into SETUP with no idle gap.
              pollFlag <= 1'b1;
              latRS    <= 1'b0;
              latRW    <= 1'b1;
              pollCnt  <= pollCnt + 1'b1;
              state    <= SETUP;
            end
          end
        end
      endcase
    end
  end

  assign inXfer     = (state != IDLE);
  assign reqReady   = (state == IDLE);
  assign lcdE       = (state == ENABLE);
  assign lcdRS      = inXfer & latRS;
  assign lcdRW      = inXfer & latRW;
  assign lcdDataOut = inXfer ? latData : 8'h00;
  assign lcdDataOe  = inXfer & ~pollFlag & ~latRW;

endmodule
